// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the iterative ALU.
// Imported by alu_iter and alu_divider.
package alu_pkg;

    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] OP_AND  = 4'b0000;
    localparam logic [ALUOP_W-1:0] OP_OR   = 4'b0001;
    localparam logic [ALUOP_W-1:0] OP_XOR  = 4'b0010;
    localparam logic [ALUOP_W-1:0] OP_NOR  = 4'b0011;
    localparam logic [ALUOP_W-1:0] OP_SLT  = 4'b0100;
    localparam logic [ALUOP_W-1:0] OP_ADD  = 4'b0101;
    localparam logic [ALUOP_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [ALUOP_W-1:0] OP_MODU = 4'b0111;
    localparam logic [ALUOP_W-1:0] OP_SLTU = 4'b1000;
    localparam logic [ALUOP_W-1:0] OP_DIVU = 4'b1001;
    localparam logic [ALUOP_W-1:0] OP_SLL  = 4'b1010;
    localparam logic [ALUOP_W-1:0] OP_SRL  = 4'b1011;
    localparam logic [ALUOP_W-1:0] OP_SRA  = 4'b1100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// Done marks the cycle whose edge completes the last iteration.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // One restoring step: shift in the next dividend bit, try to subtract.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (trial[WIDTH]) begin
            rem_nx = shifted[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    assign Busy      = busy_q;
    assign Done      = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign Quotient  = quo_nx;
    assign Remainder = rem_nx;

    // Load operands on Start, then iterate until the last bit is produced.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (Start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= Dividend;
            dvs_q  <= Divisor;
        end else if (busy_q) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 1'b1;
            if (Done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative DIVU/MODU.
// Out_Valid is a one-cycle writeback enable; results and flags hold otherwise.
module alu_iter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [ALUOP_W-1:0] ALUOp,
    output logic               Out_Valid,
    output logic [WIDTH-1:0]   Result,
    output logic               C,
    output logic               V,
    output logic               Z,
    output logic               DZ,
    output logic               Err
);

    state_t state_q;
    state_t state_d;

    logic             accept;
    logic             is_div_op;
    logic             div_start;
    logic             mod_q;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_res;

    logic             sub;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0] res_d;
    logic             c_d;
    logic             v_d;
    logic             dz_d;
    logic             err_d;

    assign accept    = In_Valid && In_Ready;
    assign is_div_op = (ALUOp == OP_DIVU) || (ALUOp == OP_MODU);
    assign div_start = accept && is_div_op && (B != '0);
    assign div_res   = mod_q ? div_rem : div_quo;
    assign shamt     = B[SHW-1:0];

    alu_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (div_start),
        .Dividend (A),
        .Divisor  (B),
        .Busy     (div_busy),
        .Done     (div_done),
        .Quotient (div_quo),
        .Remainder(div_rem)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter DIV on a nonzero-divisor divide; leave when the divider finishes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (div_start) state_d = ST_DIV;
            ST_DIV:  if (div_done || !div_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Accept new work only while idle.
    always_comb begin
        In_Ready = (state_q == ST_IDLE);
    end

    // Shared adder: SUB, SLT and SLTU all take the A + ~B + 1 path.
    always_comb begin
        sub         = (ALUOp != OP_ADD);
        b_in        = sub ? ~B : B;
        {cout, sum} = {1'b0, A} + {1'b0, b_in} + {{WIDTH{1'b0}}, sub};
        ovf         = (A[WIDTH-1] == b_in[WIDTH-1]) &&
                      (sum[WIDTH-1] != A[WIDTH-1]);
    end

    // Single-cycle result and flags, including the zero-divisor bypass.
    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        dz_d  = 1'b0;
        err_d = 1'b0;
        case (ALUOp)
            OP_AND:  res_d = A & B;
            OP_OR:   res_d = A | B;
            OP_XOR:  res_d = A ^ B;
            OP_NOR:  res_d = ~(A | B);
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, ~cout};
            OP_ADD, OP_SUB: begin
                res_d = sum;
                c_d   = cout;
                v_d   = ovf;
            end
            OP_DIVU: begin
                res_d = '1;
                dz_d  = 1'b1;
            end
            OP_MODU: begin
                res_d = A;
                dz_d  = 1'b1;
            end
            OP_SLL:  res_d = A << shamt;
            OP_SRL:  res_d = A >> shamt;
            OP_SRA:  res_d = $signed(A) >>> shamt;
            default: err_d = 1'b1;
        endcase
    end

    // Remember whether the running division should return the remainder.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mod_q <= 1'b0;
        end else if (div_start) begin
            mod_q <= (ALUOp == OP_MODU);
        end
    end

    // Result/flag registers update only together with the Out_Valid pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out_Valid <= 1'b0;
            Result    <= '0;
            C         <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
            DZ        <= 1'b0;
            Err       <= 1'b0;
        end else begin
            Out_Valid <= 1'b0;
            if (div_done) begin
                Out_Valid <= 1'b1;
                Result    <= div_res;
                C         <= 1'b0;
                V         <= 1'b0;
                Z         <= (div_res == '0);
                DZ        <= 1'b0;
                Err       <= 1'b0;
            end else if (accept && !div_start) begin
                Out_Valid <= 1'b1;
                Result    <= res_d;
                C         <= c_d;
                V         <= v_d;
                Z         <= (res_d == '0);
                DZ        <= dz_d;
                Err       <= err_d;
            end
        end
    end

endmodule
